sram_like_data_ram: RTL and testbench

- Responder end of the data sram-like interface: the memory-side slave that the write-through d_cache (or the uncached path) issues requests to.
- Accepts requests via req/addr_ok, returns read data or write completion via data_ok after a fixed latency.
- Holds up to MAX_OUTSTANDING in-flight requests and retires them strictly in order.
- Used as the bench/SoC-sim data memory behind the cache, in place of the AXI bridge.

---
 rtl/sram_like_pkg.sv | 33 +++
 rtl/sram_like_resp_queue.sv | 86 ++++++++
 rtl/sram_like_data_ram.sv | 89 ++++++++
 tb/tb_sram_like_data_ram.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// rtl/sram_like_pkg.sv - sram-like size encodings, request control fields and lane-mask helpers
// Shared with the d_cache write-mask path so both ends agree on lane selection.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    logic [1:0] addr_lo;
  } req_ctl_t;

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << addr_lo;
      SIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_expand(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) || (size[1] && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/sram_like_resp_queue.sv
// rtl/sram_like_resp_queue.sv - in-order circular queue of accepted requests with per-entry countdown
// head_ready means the oldest entry's countdown has expired and it retires this cycle.
module sram_like_resp_queue
  import sram_like_pkg::*;
#(
  parameter int IDX_W   = 12,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  req_ctl_t         push_ctl,
  input  logic [IDX_W-1:0] push_index,
  input  logic [31:0]      push_wdata,
  input  logic             pop,
  output logic             full,
  output logic             head_valid,
  output logic             head_ready,
  output req_ctl_t         head_ctl,
  output logic [IDX_W-1:0] head_index,
  output logic [31:0]      head_wdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [3:0]       CD_INIT  = 4'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  req_ctl_t         ctl_q   [DEPTH];
  logic [IDX_W-1:0] index_q [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [3:0]       cd_q    [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full       = (count_q == CNT_MAX);
    head_valid = (count_q != '0);
    head_ready = head_valid && (cd_q[head_q] == 4'd0);
    head_ctl   = ctl_q[head_q];
    head_index = index_q[head_q];
    head_wdata = wdata_q[head_q];
    do_pop     = pop && head_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctl_q[i]   <= '0;
        index_q[i] <= '0;
        wdata_q[i] <= '0;
        cd_q[i]    <= '0;
      end
    end else begin
      // Every live countdown ticks each cycle so queued entries age in parallel with the head.
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (tail_q == PTR_W'(i))) begin
          ctl_q[i]   <= push_ctl;
          index_q[i] <= push_index;
          wdata_q[i] <= push_wdata;
          cd_q[i]    <= CD_INIT;
        end else if (cd_q[i] != 4'd0) begin
          cd_q[i] <= cd_q[i] - 4'd1;
        end
      end
      if (push)   tail_q <= ptr_inc(tail_q);
      if (do_pop) head_q <= ptr_inc(head_q);
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_data_ram.sv
// rtl/sram_like_data_ram.sv - sram-like data memory responder with fixed latency and in-order retirement
// Optional DRAM_EXCEPT_EN: misaligned accesses retire with dataram_except and no memory effect.
module sram_like_data_ram
  import sram_like_pkg::*;
#(
  parameter int ADDR_WIDTH      = 12,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok
`ifdef DRAM_EXCEPT_EN
  ,
  output logic        dataram_except
`endif
);

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  full, head_valid, head_ready, head_bad;
  req_ctl_t              push_ctl, head_ctl;
  logic [ADDR_WIDTH-1:0] head_index;
  logic [31:0]           head_wdata, commit_lanes;
  logic                  unused_bits;

  // High address bits alias onto the same word.
  assign unused_bits = ^{data_addr[31:ADDR_WIDTH+2], head_valid};

  assign data_addr_ok = data_req && !rst && (!full || head_ready);

  always_comb begin
    push_ctl         = '0;
    push_ctl.wr      = data_wr;
    push_ctl.size    = data_size;
    push_ctl.addr_lo = data_addr[1:0];
  end

  sram_like_resp_queue #(
    .IDX_W   (ADDR_WIDTH),
    .LATENCY (LATENCY),
    .DEPTH   (MAX_OUTSTANDING)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (data_addr_ok),
    .push_ctl   (push_ctl),
    .push_index (data_addr[ADDR_WIDTH+1:2]),
    .push_wdata (data_wdata),
    .pop        (head_ready),
    .full       (full),
    .head_valid (head_valid),
    .head_ready (head_ready),
    .head_ctl   (head_ctl),
    .head_index (head_index),
    .head_wdata (head_wdata)
  );

`ifdef DRAM_EXCEPT_EN
  assign head_bad       = misaligned(head_ctl.size, head_ctl.addr_lo);
  assign dataram_except = head_ready && head_bad;
`else
  assign head_bad = 1'b0;
`endif

  always_comb begin
    data_data_ok = head_ready;
    data_rdata   = '0;
    commit_lanes = '0;
    if (head_ready && !head_bad) begin
      if (head_ctl.wr) commit_lanes = lane_expand(byte_mask(head_ctl.size, head_ctl.addr_lo));
      else             data_rdata   = mem[head_index];
    end
  end

  // Write commits at the edge that ends its data_ok cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_lanes != '0)
      mem[head_index] <= (mem[head_index] & ~commit_lanes) | (head_wdata & commit_lanes);
  end

endmodule

// File: tb/tb_sram_like_data_ram.sv
// tb/tb_sram_like_data_ram.sv - directed bench for sram_like_data_ram (LATENCY 3, MAX_OUTSTANDING 2)
// Exercises dataram_except when built with DRAM_EXCEPT_EN.
module tb_sram_like_data_ram;
  import sram_like_pkg::*;

  localparam int AW   = 12;
  localparam int LAT  = 3;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
`ifdef DRAM_EXCEPT_EN
  logic        dataram_except;
  logic        last_exc;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_like_data_ram #(
    .ADDR_WIDTH      (AW),
    .LATENCY         (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_req       (data_req),
    .data_wr        (data_wr),
    .data_size      (data_size),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_rdata     (data_rdata),
    .data_addr_ok   (data_addr_ok),
    .data_data_ok   (data_data_ok)
`ifdef DRAM_EXCEPT_EN
    ,
    .dataram_except (dataram_except)
`endif
  );

  task automatic send(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, output logic ok);
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = addr; data_wdata = wd;
    @(negedge clk);
    ok = data_addr_ok;
    @(posedge clk); #1;
    data_req = 1'b0;
  endtask

  task automatic wait_ok(output int lat, output logic [31:0] rd);
    lat = 0;
    rd  = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (data_data_ok) begin
        lat = n;
        rd  = data_rdata;
`ifdef DRAM_EXCEPT_EN
        last_exc = dataram_except;
`endif
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_WORD;
    data_addr = '0; data_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (data_addr_ok !== 1'b0) begin bad++; $display("FAIL reset_addr_ok: got %b want 0", data_addr_ok); end
    total++; if (data_data_ok !== 1'b0) begin bad++; $display("FAIL reset_data_ok: got %b want 0", data_data_ok); end
    total++; if (data_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", data_rdata); end
    data_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_word_rw();
    logic ok; int lat; logic [31:0] rd;
    send(1'b1, SIZE_WORD, 32'h100, 32'hDEADBEEF, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL word_wr_accept: got %b want 1", ok); end
    wait_ok(lat, rd);
    total++; if (lat != LAT) begin bad++; $display("FAIL word_wr_latency: got %0d want %0d", lat, LAT); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL word_wr_rdata: got %h want 0", rd); end
    send(1'b0, SIZE_WORD, 32'h100, 32'h0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL word_rd_accept: got %b want 1", ok); end
    wait_ok(lat, rd);
    total++; if (lat != LAT) begin bad++; $display("FAIL word_rd_latency: got %0d want %0d", lat, LAT); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_rd_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_merge();
    logic ok; int lat; logic [31:0] rd;
    send(1'b1, SIZE_WORD, 32'h20, 32'h11223344, ok); wait_ok(lat, rd);
    send(1'b1, SIZE_BYTE, 32'h21, 32'h0000AA00, ok); wait_ok(lat, rd);
    send(1'b0, SIZE_WORD, 32'h20, 32'h0, ok);        wait_ok(lat, rd);
    total++; if (rd !== 32'h1122AA44) begin bad++; $display("FAIL byte_merge: got %h want 1122aa44", rd); end
    send(1'b1, SIZE_HALF, 32'h22, 32'h55660000, ok); wait_ok(lat, rd);
    send(1'b0, SIZE_WORD, 32'h20, 32'h0, ok);        wait_ok(lat, rd);
    total++; if (rd !== 32'h5566AA44) begin bad++; $display("FAIL half_merge: got %h want 5566aa44", rd); end
  endtask

  task automatic test_wrap_alias();
    logic ok; int lat; logic [31:0] rd;
    send(1'b1, SIZE_WORD, 32'h0, 32'h5, ok);  wait_ok(lat, rd);
    send(1'b0, SIZE_WORD, 32'h1 << (AW + 2), 32'h0, ok); wait_ok(lat, rd);
    total++; if (rd !== 32'h5) begin bad++; $display("FAIL wrap_alias: got %h want 5", rd); end
  endtask

`ifdef DRAM_EXCEPT_EN
  task automatic test_except();
    logic ok; int lat; logic [31:0] rd;
    send(1'b0, SIZE_WORD, 32'h102, 32'h0, ok); wait_ok(lat, rd);
    total++; if (last_exc !== 1'b1) begin bad++; $display("FAIL except_rd_flag: got %b want 1", last_exc); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL except_rd_data: got %h want 0", rd); end
    send(1'b1, SIZE_HALF, 32'h101, 32'hFFFFFFFF, ok); wait_ok(lat, rd);
    total++; if (last_exc !== 1'b1) begin bad++; $display("FAIL except_wr_flag: got %b want 1", last_exc); end
    send(1'b0, SIZE_WORD, 32'h100, 32'h0, ok); wait_ok(lat, rd);
    total++; if (last_exc !== 1'b0) begin bad++; $display("FAIL except_clean_flag: got %b want 0", last_exc); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL except_mem_kept: got %h want deadbeef", rd); end
  endtask
`else
  task automatic test_misaligned();
    logic ok; int lat; logic [31:0] rd;
    send(1'b1, SIZE_WORD, 32'h42, 32'hCAFEF00D, ok); wait_ok(lat, rd);
    send(1'b0, SIZE_WORD, 32'h40, 32'h0, ok);        wait_ok(lat, rd);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL misaligned_word: got %h want cafef00d", rd); end
    send(1'b1, SIZE_HALF, 32'h41, 32'h0000BEEF, ok); wait_ok(lat, rd);
    send(1'b0, SIZE_WORD, 32'h40, 32'h0, ok);        wait_ok(lat, rd);
    total++; if (rd !== 32'hCAFEBEEF) begin bad++; $display("FAIL misaligned_half: got %h want cafebeef", rd); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] addrs  [3];
    logic        exp_aok[7];
    logic        exp_dok[7];
    logic [31:0] exp_rd [7];
    int   idx;
    logic acc;
    addrs = '{32'h100, 32'h20, 32'h4000};
    exp_aok = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_dok = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_rd  = '{32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h5566AA44, 32'h0, 32'h5};
    idx = 0;
    acc = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (acc) idx++;
      data_req  = (idx < 3);
      data_wr   = 1'b0;
      data_size = SIZE_WORD;
      data_addr = addrs[(idx < 3) ? idx : 2];
      @(negedge clk);
      acc = data_req & data_addr_ok;
      total++; if (data_addr_ok !== exp_aok[k]) begin bad++; $display("FAIL b2b_addr_ok[%0d]: got %b want %b", k, data_addr_ok, exp_aok[k]); end
      total++; if (data_data_ok !== exp_dok[k]) begin bad++; $display("FAIL b2b_data_ok[%0d]: got %b want %b", k, data_data_ok, exp_dok[k]); end
      total++; if (data_rdata !== exp_rd[k]) begin bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, data_rdata, exp_rd[k]); end
    end
    data_req = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic ok; int lat; logic [31:0] rd; int stray;
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b1; data_size = SIZE_WORD;
    data_addr = 32'h100; data_wdata = 32'h12345678;
    @(posedge clk); #1;
    data_addr = 32'h20; data_wdata = 32'h87654321;
    @(posedge clk); #1;
    data_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (data_data_ok !== 1'b1) begin bad++; $display("FAIL midrst_pre_data_ok: got %b want 1", data_data_ok); end
    #1;
    data_req = 1'b1;
    rst = 1'b1;
    #1;
    total++; if (data_data_ok !== 1'b0) begin bad++; $display("FAIL midrst_data_ok: got %b want 0", data_data_ok); end
    total++; if (data_addr_ok !== 1'b0) begin bad++; $display("FAIL midrst_addr_ok: got %b want 0", data_addr_ok); end
    total++; if (data_rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata: got %h want 0", data_rdata); end
    @(posedge clk); #1;
    data_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (data_data_ok) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL midrst_stray_ok: got %0d want 0", stray); end
    send(1'b0, SIZE_WORD, 32'h100, 32'h0, ok); wait_ok(lat, rd);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL midrst_mem_a: got %h want deadbeef", rd); end
    send(1'b0, SIZE_WORD, 32'h20, 32'h0, ok); wait_ok(lat, rd);
    total++; if (rd !== 32'h5566AA44) begin bad++; $display("FAIL midrst_mem_b: got %h want 5566aa44", rd); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_merge();
    test_wrap_alias();
`ifdef DRAM_EXCEPT_EN
    test_except();
`else
    test_misaligned();
`endif
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
